// File: rtl/bus_master_if_pkg.sv
// rtl/bus_master_if_pkg.sv - shared bus encodings, FSM states and default widths
package bus_master_if_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEF_ADDR_W  = 30;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2,
        BUS_IF_STALL  = 2'd3
    } bus_if_state_e;

    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - initiator-side bus interface: arbitration request, single
// word access, completion/stall/flush handling and no-response timeout
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_as_,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rw,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_rdy_,
    output logic              busy,
    output logic              bus_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    bus_if_state_e     r_state,        w_state_nxt;
    logic              r_bus_req_,     w_bus_req_nxt;
    logic              r_bus_as_,      w_bus_as_nxt;
    logic              r_bus_rw,       w_bus_rw_nxt;
    logic [ADDR_W-1:0] r_bus_addr,     w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wr_data,  w_bus_wr_data_nxt;
    logic [DATA_W-1:0] r_core_rd_data, w_core_rd_data_nxt;
    logic              r_core_rdy_,    w_core_rdy_nxt;
    logic              r_bus_err,      w_bus_err_nxt;
    logic [CNT_W-1:0]  r_cnt,          w_cnt_nxt;
    logic              w_sample;
    logic              w_timeout_hit;

    // The cycle carrying the address strobe is not a response window.
    assign w_sample      = (r_bus_as_ == DISABLE_);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt        = r_state;
        w_bus_req_nxt      = r_bus_req_;
        w_bus_as_nxt       = DISABLE_;
        w_bus_rw_nxt       = r_bus_rw;
        w_bus_addr_nxt     = r_bus_addr;
        w_bus_wr_data_nxt  = r_bus_wr_data;
        w_core_rd_data_nxt = r_core_rd_data;
        w_core_rdy_nxt     = DISABLE_;
        w_bus_err_nxt      = 1'b0;
        w_cnt_nxt          = r_cnt;

        case (r_state)
            BUS_IF_IDLE: begin
                if (core_as_ == ENABLE_ && !flush) begin
                    w_bus_addr_nxt    = core_addr;
                    w_bus_rw_nxt      = core_rw;
                    w_bus_wr_data_nxt = core_wr_data;
                    w_bus_req_nxt     = ENABLE_;
                    w_state_nxt       = BUS_IF_REQ;
                end
            end
            BUS_IF_REQ: begin
                if (flush) begin
                    w_bus_req_nxt = DISABLE_;
                    w_state_nxt   = BUS_IF_IDLE;
                end else if (bus_grnt_ == ENABLE_) begin
                    w_bus_as_nxt = ENABLE_;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = BUS_IF_ACCESS;
                end
            end
            BUS_IF_ACCESS: begin
                if (w_sample) begin
                    if (bus_rdy_ == ENABLE_) begin
                        if (r_bus_rw == READ) begin
                            w_core_rd_data_nxt = bus_rd_data;
                        end
                        w_core_rdy_nxt = ENABLE_;
                        w_bus_req_nxt  = DISABLE_;
                        w_state_nxt    = stall ? BUS_IF_STALL : BUS_IF_IDLE;
                    end else if (w_timeout_hit) begin
                        w_bus_err_nxt = 1'b1;
                        w_bus_req_nxt = DISABLE_;
                        w_state_nxt   = BUS_IF_IDLE;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            BUS_IF_STALL: begin
                if (!stall) begin
                    w_state_nxt = BUS_IF_IDLE;
                end
            end
            default: w_state_nxt = BUS_IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= BUS_IF_IDLE;
            r_bus_req_     <= DISABLE_;
            r_bus_as_      <= DISABLE_;
            r_bus_rw       <= READ;
            r_bus_addr     <= '0;
            r_bus_wr_data  <= '0;
            r_core_rd_data <= '0;
            r_core_rdy_    <= DISABLE_;
            r_bus_err      <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_req_     <= w_bus_req_nxt;
            r_bus_as_      <= w_bus_as_nxt;
            r_bus_rw       <= w_bus_rw_nxt;
            r_bus_addr     <= w_bus_addr_nxt;
            r_bus_wr_data  <= w_bus_wr_data_nxt;
            r_core_rd_data <= w_core_rd_data_nxt;
            r_core_rdy_    <= w_core_rdy_nxt;
            r_bus_err      <= w_bus_err_nxt;
            r_cnt          <= w_cnt_nxt;
        end
    end

    assign busy = ((r_state == BUS_IF_IDLE) && (core_as_ == ENABLE_) && !flush)
                || (r_state == BUS_IF_REQ) || (r_state == BUS_IF_ACCESS);

    assign bus_req_     = r_bus_req_;
    assign bus_as_      = r_bus_as_;
    assign bus_rw       = r_bus_rw;
    assign bus_addr     = r_bus_addr;
    assign bus_wr_data  = r_bus_wr_data;
    assign core_rd_data = r_core_rd_data;
    assign core_rdy_    = r_core_rdy_;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - self-checking bench for bus_master_if
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_as_ = 1'b1;
    logic [29:0] core_addr = '0;
    logic        core_rw = 1'b1;
    logic [31:0] core_wr_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] core_rd_data;
    logic        core_rdy_;
    logic        busy;
    logic        bus_err;
    logic        bus_req_;
    logic        bus_grnt_ = 1'b1;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data = '0;
    logic        bus_rdy_ = 1'b1;

    int total = 0;
    int bad = 0;
    logic [31:0] m_rd = '0;

    bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .core_as_(core_as_), .core_addr(core_addr),
        .core_rw(core_rw), .core_wr_data(core_wr_data), .stall(stall), .flush(flush),
        .core_rd_data(core_rd_data), .core_rdy_(core_rdy_), .busy(busy),
        .bus_err(bus_err), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;         // REQ cycles before the arbiter grants
        int          w;         // slave wait states
        int          stall_n;   // stall cycles after completion
        int          flush_at;  // REQ cycle index of flush (>g: flush in ACCESS), -1 none
        bit          hold;      // core keeps core_as_ low after completion
        int          exp_rdy;
        int          exp_err;
        int          exp_as;
        int          exp_evt;   // observation index at which bus_req_ is released
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [29:0] a, input logic rw, input logic [31:0] wd,
                                input logic [31:0] rd, input int g, input int w, input int st,
                                input int fa, input bit hold, input int e_rdy, input int e_err,
                                input int e_as, input int e_evt, input logic [31:0] e_rd);
        vec_t v;
        v.addr = a; v.rw = rw; v.wdata = wd; v.rdata = rd; v.g = g; v.w = w;
        v.stall_n = st; v.flush_at = fa; v.hold = hold; v.exp_rdy = e_rdy;
        v.exp_err = e_err; v.exp_as = e_as; v.exp_evt = e_evt; v.exp_rd = e_rd;
        return v;
    endfunction

    // Outcome of one access from the rules: flush before/at grant abandons it,
    // a slave slower than TMO response cycles times out, otherwise it completes.
    function automatic vec_t predict(input vec_t v, input logic [31:0] prev_rd);
        vec_t r;
        bit aborted;
        bit tmo;
        r = v;
        aborted = (v.flush_at >= 0) && (v.flush_at <= v.g);
        tmo = !aborted && (TMO > 0) && (v.w >= TMO);
        r.exp_as  = aborted ? 0 : 1;
        r.exp_err = tmo ? 1 : 0;
        r.exp_rdy = (!aborted && !tmo) ? 1 : 0;
        if (aborted)  r.exp_evt = v.flush_at + 2;
        else if (tmo) r.exp_evt = v.g + 3 + TMO;
        else          r.exp_evt = v.g + 4 + v.w;
        r.exp_rd = (r.exp_rdy == 1 && v.rw == READ) ? v.rdata : prev_rd;
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 64'(bus_req_), 64'(1));
        chk({tag, "_as"}, 64'(bus_as_), 64'(1));
        chk({tag, "_rw"}, 64'(bus_rw), 64'(READ));
        chk({tag, "_addr"}, 64'(bus_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(bus_wr_data), 64'(0));
        chk({tag, "_rdata"}, 64'(core_rd_data), 64'(0));
        chk({tag, "_rdy"}, 64'(core_rdy_), 64'(1));
        chk({tag, "_err"}, 64'(bus_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // Starts and ends on a falling edge; the bench plays core, arbiter and slave.
    task automatic run_txn(input vec_t v);
        int req_cnt = 0, samp = 0, rdy_n = 0, err_n = 0, as_n = 0, evt = 0;
        int stall_left = 0, stab_bad = 0, bsy_bad = 0;
        bit as_seen = 0, done = 0, req_was_low = 0;
        core_addr = v.addr; core_rw = v.rw; core_wr_data = v.wdata;
        core_as_ = 1'b0; flush = 1'b0; stall = 1'b0;
        for (int k = 1; k <= 80 && !(done && stall_left == 0); k++) begin
            @(posedge clk); @(negedge clk);
            if (!bus_req_) begin
                req_cnt++;
                req_was_low = 1;
            end else if (req_was_low && !done) begin
                evt = k;
                done = 1;
                stall_left = (!core_rdy_) ? v.stall_n : 0;
            end
            if (!bus_as_) begin
                as_n++; as_seen = 1; samp = 0;
                if (busy !== 1'b1) bsy_bad++;
            end else if (as_seen && !done) begin
                samp++;
            end
            if (as_seen && (!done || !core_rdy_) &&
                (bus_addr !== v.addr || bus_rw !== v.rw || bus_wr_data !== v.wdata))
                stab_bad++;
            if (!core_rdy_) rdy_n++;
            if (bus_err) err_n++;
            if (done && stall_left > 0) begin
                if (bus_req_ !== 1'b1 || busy !== 1'b0) bsy_bad++;
                stall_left--;
            end
            if (done && !v.hold) core_as_ = 1'b1;
            flush = 1'b0;
            if (!done && !as_seen && !bus_req_ && v.flush_at >= 0 && req_cnt == v.flush_at + 1) begin
                flush = 1'b1;
                core_as_ = 1'b1;
            end else if (!done && as_seen && samp == 0 && v.flush_at > v.g) begin
                flush = 1'b1;
            end
            bus_grnt_ = !(!bus_req_ && req_cnt > v.g && !done);
            bus_rdy_ = 1'b1;
            bus_rd_data = $urandom;
            stall = done && stall_left > 0;
            if (as_seen && !done) begin
                if (samp == 0) begin
                    bus_rdy_ = 1'b0;
                end else if (samp == v.w + 1) begin
                    bus_rdy_ = 1'b0;
                    bus_rd_data = v.rdata;
                    stall = (v.stall_n > 0);
                end
            end
        end
        chk("txn_finished", 64'(done), 64'(1));
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; flush = 1'b0; stall = 1'b0;
        chk("rdy_pulses", 64'(rdy_n), 64'(v.exp_rdy));
        chk("err_pulses", 64'(err_n), 64'(v.exp_err));
        chk("as_cycles", 64'(as_n), 64'(v.exp_as));
        chk("release_cycle", 64'(evt), 64'(v.exp_evt));
        chk("rd_data", 64'(core_rd_data), 64'(v.exp_rd));
        chk("bus_stable", 64'(stab_bad), 64'(0));
        chk("busy_stall", 64'(bsy_bad), 64'(0));
        @(posedge clk); @(negedge clk);
        chk("post_req_high", 64'(bus_req_), 64'(1));
        if (v.hold) begin
            @(posedge clk); @(negedge clk);
            chk("rereq_after_stall", 64'(bus_req_), 64'(0));
            flush = 1'b1; core_as_ = 1'b1;
            @(posedge clk); @(negedge clk);
            flush = 1'b0;
            chk("rereq_flushed", 64'(bus_req_), 64'(1));
            @(posedge clk); @(negedge clk);
        end
        chk("post_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = mk(30'h0000_0100, READ, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, -1, 0,
                    1, 0, 1, 4, 32'hDEAD_BEEF);
        tbl[1] = mk(30'h0000_3ABC, WRITE, 32'h1234_5678, 32'hFFFF_0000, 0, 3, 0, -1, 0,
                    1, 0, 1, 7, 32'hDEAD_BEEF);
        tbl[2] = mk(30'h0000_0777, READ, 32'h0, 32'h1111_1111, 5, 0, 0, 3, 0,
                    0, 0, 0, 5, 32'hDEAD_BEEF);
        tbl[3] = mk(30'h0000_0040, READ, 32'h0, 32'h2222_2222, 0, 100, 0, -1, 0,
                    0, 1, 1, 7, 32'hDEAD_BEEF);
        tbl[4] = mk(30'h2AAA_AAAA, READ, 32'h0, 32'h0BAD_F00D, 1, 3, 0, -1, 0,
                    1, 0, 1, 8, 32'h0BAD_F00D);
        tbl[5] = mk(30'h0000_0200, READ, 32'h0, 32'h0000_00A5, 0, 0, 3, -1, 1,
                    1, 0, 1, 4, 32'h0000_00A5);
        tbl[6] = mk(30'h1555_0001, READ, 32'h0, 32'h5A5A_0001, 2, 2, 1, 5, 0,
                    1, 0, 1, 8, 32'h5A5A_0001);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        reset = 1'b1;
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            m_rd = tbl[i].exp_rd;
        end

        // Reset asserted while a write is in its response window.
        core_addr = 30'h0000_0155; core_rw = WRITE; core_wr_data = 32'hCAFE_F00D; core_as_ = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_req", 64'(bus_req_), 64'(0));
        bus_grnt_ = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_as", 64'(bus_as_), 64'(0));
        @(posedge clk); @(negedge clk);
        #2;
        reset = 1'b0; core_as_ = 1'b1; bus_grnt_ = 1'b1;
        #1;
        chk_reset("async_rst");
        @(posedge clk); @(negedge clk);
        chk("rst_held_req", 64'(bus_req_), 64'(1));
        reset = 1'b1;
        m_rd = '0;
        @(posedge clk); @(negedge clk);
        v = predict(mk(30'h0000_0888, READ, 32'h0, 32'h600D_1234, 0, 1, 0, -1, 0,
                       0, 0, 0, 0, 32'h0), m_rd);
        run_txn(v);
        m_rd = v.exp_rd;

        for (int i = 0; i < 40; i++) begin
            v.addr = 30'($urandom);
            v.rw = 1'($urandom);
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.g = int'($urandom_range(0, 3));
            v.w = int'($urandom_range(0, 6));
            v.stall_n = int'($urandom_range(0, 2));
            v.flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            v.hold = 1'b0;
            v = predict(v, m_rd);
            run_txn(v);
            m_rd = v.exp_rd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
